bus_arbiter: RTL

- Single-outstanding req/gnt/rvalid arbiter that shares one memory/peripheral bus slave port between NUM_MASTERS requesters.
- Typical requesters: core instruction fetch, core LSU, debug system-bus-access master.
- Sits between the masters and the bus fabric; owns transaction sequencing, fairness and response routing.
- Has a response timeout so a hung slave cannot lock out the debugger.

---
 rtl/bus_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// Single-outstanding req/gnt/rvalid arbiter sharing one slave port among NUM_MASTERS requesters.
// Round-robin or fixed-priority selection, combinational address path, response timeout.
module bus_arbiter #(
    parameter int NUM_MASTERS = 3,
    parameter bit RR_EN       = 1'b1,
    parameter int TIMEOUT     = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_MASTERS-1:0]    m_req_i,
    input  logic [NUM_MASTERS-1:0]    m_we_i,
    input  logic [4*NUM_MASTERS-1:0]  m_be_i,
    input  logic [32*NUM_MASTERS-1:0] m_addr_i,
    input  logic [32*NUM_MASTERS-1:0] m_wdata_i,
    output logic [NUM_MASTERS-1:0]    m_gnt_o,
    output logic [NUM_MASTERS-1:0]    m_rvalid_o,
    output logic [31:0]               m_rdata_o,
    output logic                      m_err_o,
    output logic                      s_req_o,
    output logic                      s_we_o,
    output logic [3:0]                s_be_o,
    output logic [31:0]               s_addr_o,
    output logic [31:0]               s_wdata_o,
    input  logic                      s_gnt_i,
    input  logic                      s_rvalid_i,
    input  logic [31:0]               s_rdata_i,
    input  logic                      s_err_i,
    output logic                      busy_o,
    output logic [2:0]                owner_o
);

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        ADDR = 3'b010,
        RESP = 3'b100
    } state_t;

    state_t                 state, state_nxt;
    logic [2:0]             owner, owner_nxt, rr_ptr, rr_nxt, winner, sel;
    logic                   found, owner_req;
    logic [NUM_MASTERS-1:0] sel_oh;
    logic [15:0]            tcnt, tcnt_nxt;

    // First pass: masters above rr_ptr (RR) or everyone (fixed); second pass wraps to the lowest.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int j = 0; j < NUM_MASTERS; j++) begin
            if (!found && m_req_i[j] && (!RR_EN || 3'(j) > rr_ptr)) begin
                winner = 3'(j);
                found  = 1'b1;
            end
        end
        for (int j = 0; j < NUM_MASTERS; j++) begin
            if (!found && m_req_i[j]) begin
                winner = 3'(j);
                found  = 1'b1;
            end
        end
    end

    assign sel = (state == IDLE) ? winner : owner;

    always_comb begin
        sel_oh    = '0;
        s_we_o    = 1'b0;
        s_be_o    = '0;
        s_addr_o  = '0;
        s_wdata_o = '0;
        for (int j = 0; j < NUM_MASTERS; j++) begin
            if (sel == 3'(j)) begin
                sel_oh[j] = 1'b1;
                s_we_o    = m_we_i[j];
                s_be_o    = m_be_i[4*j +: 4];
                s_addr_o  = m_addr_i[32*j +: 32];
                s_wdata_o = m_wdata_i[32*j +: 32];
            end
        end
    end

    assign owner_req = |(m_req_i & sel_oh);

    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        rr_nxt     = rr_ptr;
        tcnt_nxt   = '0;
        s_req_o    = 1'b0;
        m_gnt_o    = '0;
        m_rvalid_o = '0;
        m_rdata_o  = '0;
        m_err_o    = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    s_req_o   = 1'b1;
                    owner_nxt = winner;
                    if (s_gnt_i) begin
                        m_gnt_o   = sel_oh;
                        rr_nxt    = winner;
                        state_nxt = RESP;
                    end else begin
                        state_nxt = ADDR;
                    end
                end
            end
            ADDR: begin
                s_req_o = owner_req;
                if (owner_req && s_gnt_i) begin
                    m_gnt_o   = sel_oh;
                    rr_nxt    = owner;
                    state_nxt = RESP;
                end else if (!owner_req) begin
                    state_nxt = IDLE;
                end
            end
            RESP: begin
                tcnt_nxt = tcnt + 16'd1;
                if (s_rvalid_i) begin
                    m_rvalid_o = sel_oh;
                    m_rdata_o  = s_rdata_i;
                    m_err_o    = s_err_i;
                    tcnt_nxt   = '0;
                    state_nxt  = IDLE;
                end else if (TIMEOUT != 0 && tcnt == 16'(TIMEOUT - 1)) begin
                    m_rvalid_o = sel_oh;
                    m_err_o    = 1'b1;
                    tcnt_nxt   = '0;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // An abandoned transaction must not leak a handshake during the reset cycle.
        if (rst) begin
            s_req_o    = 1'b0;
            m_gnt_o    = '0;
            m_rvalid_o = '0;
            m_rdata_o  = '0;
            m_err_o    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= 3'(NUM_MASTERS - 1);
            tcnt   <= '0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            rr_ptr <= rr_nxt;
            tcnt   <= tcnt_nxt;
        end
    end

    assign busy_o  = (state != IDLE);
    assign owner_o = owner;

endmodule
